papuf_eval_ctrl: RTL and testbench
==================================

# papuf_eval_ctrl

Evaluation controller that sits directly upstream of the 16-bit PA-PUF array. It accepts a challenge over a valid/ready command port and drives the array's `challenge` bus and `pulse` strobe. It samples the array's `response` NEVAL times and majority-votes each bit, then returns the voted response plus a per-bit instability mask over a valid/ready result port.

## Interface
Parameters:
- CW, 16, challenge width; must equal the array challenge width.
- RW, 16, response width; must equal the array response width.
- NEVAL, 5, evaluations per command; odd, 1..15; elaboration error otherwise.
- PULSE_W, 1, cycles `puf_pulse` is held high per evaluation; ≥1.
- SETTLE, 4, cycles from pulse fall to sample; ≥3 to cover the 2-flop synchronizer.

Ports:
- clk  in  1  single clock.
- rst  in  1  reset, synchronous, active-high.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  high only in IDLE while rst low.
- cmd_challenge  in  CW  challenge, captured on cmd_valid&&cmd_ready.
- puf_challenge  out  CW  to array `challenge`.
- puf_pulse  out  1  to array `pulse`.
- puf_response  in  RW  from array `response`; asynchronous to clk.
- out_valid  out  1  result available.
- out_ready  in  1  result accepted.
- out_data  out  RW  majority-voted response.
- out_unstable  out  RW  bit set if its NEVAL samples disagreed.
- busy  out  1  high in any state other than IDLE.

## Operation
- The FSM has six states: IDLE, APPLY, PULSE, SETTLE, SAMPLE, DONE.
- IDLE -> APPLY on command accept:
  - cmd_challenge is latched into puf_challenge.
  - Per-bit ones-counters are cleared.
  - The eval counter is cleared.
- APPLY lasts 1 cycle, with the challenge stable and pulse low, then goes to PULSE.
- PULSE lasts PULSE_W cycles with puf_pulse=1, then goes to SETTLE.
- SETTLE lasts SETTLE cycles with pulse low, then goes to SAMPLE.
- SAMPLE lasts 1 cycle:
  - Each bit's ones-counter (width 4) adds the synchronized response bit.
  - The eval counter increments.
  - If the eval counter reaches NEVAL, go to DONE; otherwise go to APPLY.
- DONE:
  - out_data[i] = (cnt[i] > NEVAL/2).
  - out_unstable[i] = (cnt[i] != 0 && cnt[i] != NEVAL).
  - out_valid is held high. Outputs are registered and remain stable until out_valid&&out_ready, then the FSM goes to IDLE.
- puf_challenge is held constant from APPLY through DONE and keeps its value in IDLE.
- puf_response passes through a 2-flop synchronizer. Only the synchronized value is used.
- cmd_valid outside IDLE is ignored; no state change.
- Reset:
  - Values after reset: state=IDLE, puf_pulse=0, puf_challenge=0, out_valid=0, out_data=0, out_unstable=0, busy=0, and counters and synchronizer=0.
  - cmd_ready=0 while rst is high.
  - Reset mid-operation aborts the command. No result is produced, and puf_pulse is low from the cycle after the reset edge.

## Timing
- The command is accepted at edge E0.
- APPLY is cycle E0+1.
- The eval period is P = 2+PULSE_W+SETTLE cycles (7 at defaults).
- out_valid rises at E0 + NEVAL·P + 1 (36 at defaults).
- Exactly NEVAL pulses are issued per command; each rises at E0+2+k·P.
- The handshake at edge H (out_valid&&out_ready) puts the FSM in IDLE at H+1, with cmd_ready=1 at H+1. The earliest next accept is at H+1, so there is no same-cycle turnaround.
- out_ready held low indefinitely: the FSM stalls in DONE, with no pulses and all outputs frozen.
- All outputs are registered except cmd_ready and busy, which are decoded from state.

## Structure
- Shared package papuf_pkg holds:
  - CW/RW defaults.
  - The state enum type.
  - A function maj_thresh(NEVAL) returning NEVAL/2.
- One sub-module, papuf_maj_vote: one instance per bit, containing the ones-counter with clear/increment and the voted and unstable outputs.
- The synchronizer is inline in the top level.

## Test plan
- **Reset mid-PULSE:** rst high for 3 cycles during PULSE -> puf_pulse=0 from the next cycle, out_valid never rises, cmd_ready=1 on the first cycle after rst falls.
- **Stable model:** the model always returns 16'hA5C3 and the command is accepted at cycle 0 -> exactly 5 one-cycle pulses at cycles 2, 9, 16, 23, 30; out_valid at cycle 36 with out_data=16'hA5C3 and out_unstable=0.
- **Noisy bit0:** bit0 returns 1,0,1,0,1 with the other bits 0 -> out_data=16'h0001, out_unstable=16'h0001. A pattern of 0,1,0,1,0 -> out_data=0, out_unstable=16'h0001.
- **Back-pressure:** out_ready held low for 10 cycles after out_valid -> data stable, no pulses, busy=1, cmd_ready=0. On the handshake, busy=0 and cmd_ready=1 the next cycle.
- **Command while busy:** cmd_valid with 16'hFFFF during SETTLE of a 16'h1234 command -> puf_challenge stays 16'h1234 and the second command is not accepted until IDLE.
- **Back-to-back:** two commands, 16'h0001 and 16'h8000, with out_ready tied high -> the second is accepted one cycle after the first handshake, and its out_valid follows at accept+36.

Source files
------------

// File: rtl/papuf_pkg.sv
// Shared definitions for the PA-PUF evaluation controller.
// Holds the default array widths, the controller state type and the
// majority threshold helper used by the per-bit voters.
package papuf_pkg;

  localparam int unsigned CW_DEF = 16;
  localparam int unsigned RW_DEF = 16;
  // Ones-counter and eval-counter width; covers NEVAL up to 15.
  localparam int unsigned CNT_W  = 4;

  typedef enum logic [2:0] {
    S_IDLE,
    S_APPLY,
    S_PULSE,
    S_SETTLE,
    S_SAMPLE,
    S_DONE
  } state_t;

  // A bit votes 1 when its ones-count exceeds this value.
  function automatic int unsigned maj_thresh(input int unsigned neval);
    return neval / 2;
  endfunction

endpackage

// File: rtl/papuf_maj_vote.sv
// Per-bit majority voter for the PA-PUF evaluation controller.
// Ports:
//   clk, rst    clock and synchronous active-high reset
//   clear       zero the ones-counter (new command)
//   inc         add sample into the ones-counter (SAMPLE cycle)
//   sample      synchronized response bit
//   vote_c      majority value including the current sample
//   unstable_c  samples disagree, including the current sample
module papuf_maj_vote
  import papuf_pkg::*;
#(
  parameter int unsigned NEVAL = 5
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic inc,
  input  logic sample,
  output logic vote_c,
  output logic unstable_c
);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] sum;

  // Count as it will stand once this cycle's sample is added, so the top
  // can register the final vote on the same edge as the last sample.
  assign sum = cnt + CNT_W'(sample);

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      cnt <= '0;
    end else if (inc) begin
      cnt <= sum;
    end
  end

  assign vote_c     = (sum > CNT_W'(maj_thresh(NEVAL)));
  assign unstable_c = (sum != '0) && (sum != CNT_W'(NEVAL));

endmodule

// File: rtl/papuf_eval_ctrl.sv
// PA-PUF evaluation controller: applies a challenge, pulses the array
// NEVAL times, majority-votes the synchronized responses and returns the
// voted word plus a per-bit instability mask.
// Ports:
//   clk, rst                              clock, synchronous active-high reset
//   cmd_valid/cmd_ready/cmd_challenge      command handshake
//   puf_challenge, puf_pulse, puf_response array interface (response async)
//   out_valid/out_ready/out_data/out_unstable result handshake
//   busy                                   controller not idle
module papuf_eval_ctrl
  import papuf_pkg::*;
#(
  parameter int unsigned CW      = CW_DEF,
  parameter int unsigned RW      = RW_DEF,
  parameter int unsigned NEVAL   = 5,
  parameter int unsigned PULSE_W = 1,
  parameter int unsigned SETTLE  = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [CW-1:0] cmd_challenge,
  output logic [CW-1:0] puf_challenge,
  output logic          puf_pulse,
  input  logic [RW-1:0] puf_response,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [RW-1:0] out_data,
  output logic [RW-1:0] out_unstable,
  output logic          busy
);

  localparam int unsigned TMAX = (PULSE_W > SETTLE) ? PULSE_W : SETTLE;
  localparam int unsigned TW   = (TMAX > 1) ? $clog2(TMAX + 1) : 1;

  if ((NEVAL % 2) == 0 || NEVAL < 1 || NEVAL > 15) begin : g_bad_neval
    $error("papuf_eval_ctrl: NEVAL must be odd and within 1..15");
  end
  if (PULSE_W < 1) begin : g_bad_pulse_w
    $error("papuf_eval_ctrl: PULSE_W must be at least 1");
  end
  if (SETTLE < 3) begin : g_bad_settle
    $error("papuf_eval_ctrl: SETTLE must be at least 3");
  end

  state_t           state;
  logic [TW-1:0]    timer;
  logic [CNT_W-1:0] eval_cnt;
  logic [RW-1:0]    sync1;
  logic [RW-1:0]    sync2;
  logic [RW-1:0]    vote_c;
  logic [RW-1:0]    unstable_c;
  logic             cnt_clear;
  logic             cnt_inc;

  assign cmd_ready = (state == S_IDLE) && !rst;
  assign busy      = (state != S_IDLE);
  assign cnt_clear = (state == S_IDLE) && cmd_valid;
  assign cnt_inc   = (state == S_SAMPLE);

  for (genvar i = 0; i < RW; i++) begin : g_vote
    papuf_maj_vote #(
      .NEVAL (NEVAL)
    ) u_vote (
      .clk        (clk),
      .rst        (rst),
      .clear      (cnt_clear),
      .inc        (cnt_inc),
      .sample     (sync2[i]),
      .vote_c     (vote_c[i]),
      .unstable_c (unstable_c[i])
    );
  end

  // Controller FSM with registered array and result outputs; the response
  // synchronizer runs in every state so it is settled before SAMPLE.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= S_IDLE;
      timer         <= '0;
      eval_cnt      <= '0;
      sync1         <= '0;
      sync2         <= '0;
      puf_challenge <= '0;
      puf_pulse     <= 1'b0;
      out_valid     <= 1'b0;
      out_data      <= '0;
      out_unstable  <= '0;
    end else begin
      sync1 <= puf_response;
      sync2 <= sync1;
      case (state)
        S_IDLE: begin
          if (cmd_valid) begin
            puf_challenge <= cmd_challenge;
            eval_cnt      <= '0;
            state         <= S_APPLY;
          end
        end
        S_APPLY: begin
          puf_pulse <= 1'b1;
          timer     <= TW'(PULSE_W - 1);
          state     <= S_PULSE;
        end
        S_PULSE: begin
          if (timer == '0) begin
            puf_pulse <= 1'b0;
            timer     <= TW'(SETTLE - 1);
            state     <= S_SETTLE;
          end else begin
            timer <= timer - TW'(1);
          end
        end
        S_SETTLE: begin
          if (timer == '0) begin
            state <= S_SAMPLE;
          end else begin
            timer <= timer - TW'(1);
          end
        end
        S_SAMPLE: begin
          eval_cnt <= eval_cnt + CNT_W'(1);
          // Last evaluation: the voters already include this sample.
          if (eval_cnt == CNT_W'(NEVAL - 1)) begin
            out_valid    <= 1'b1;
            out_data     <= vote_c;
            out_unstable <= unstable_c;
            state        <= S_DONE;
          end else begin
            state <= S_APPLY;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_papuf_eval_ctrl.sv
// Self-checking bench for papuf_eval_ctrl. A behavioural array model hands
// out one queued response word per pulse; expected results come from
// counting ones per bit over the queued words, expected timing from the
// eval period formula. "Cycle c" of the timing rules is observed #1 after
// clock edge c-1, so the bench's edge index is one less than the cycle.
module tb_papuf_eval_ctrl;

  localparam int unsigned CW      = 16;
  localparam int unsigned RW      = 16;
  localparam int unsigned NEVAL   = 5;
  localparam int unsigned PULSE_W = 1;
  localparam int unsigned SETTLE  = 4;
  localparam int          P       = 2 + PULSE_W + SETTLE;

  logic          clk = 1'b0;
  logic          rst;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [CW-1:0] cmd_challenge;
  logic [CW-1:0] puf_challenge;
  logic          puf_pulse;
  logic [RW-1:0] puf_response;
  logic          out_valid;
  logic          out_ready;
  logic [RW-1:0] out_data;
  logic [RW-1:0] out_unstable;
  logic          busy;

  always #5 clk = ~clk;

  papuf_eval_ctrl #(
    .CW      (CW),
    .RW      (RW),
    .NEVAL   (NEVAL),
    .PULSE_W (PULSE_W),
    .SETTLE  (SETTLE)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .cmd_valid     (cmd_valid),
    .cmd_ready     (cmd_ready),
    .cmd_challenge (cmd_challenge),
    .puf_challenge (puf_challenge),
    .puf_pulse     (puf_pulse),
    .puf_response  (puf_response),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_data      (out_data),
    .out_unstable  (out_unstable),
    .busy          (busy)
  );

  int            total = 0;
  int            bad   = 0;
  int            cyc   = 0;
  logic          prev_pulse = 1'b0;
  logic [RW-1:0] seq [NEVAL];
  logic [RW-1:0] resp_q [$];
  int            rise_q [$];
  int            high_cnt = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock; the array model answers each new pulse with the next word.
  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    if (puf_pulse === 1'b1) begin
      high_cnt++;
      if (!prev_pulse) begin
        rise_q.push_back(cyc);
        if (resp_q.size() > 0) puf_response = resp_q.pop_front();
      end
    end
    prev_pulse = puf_pulse;
  endtask

  task automatic arm();
    resp_q.delete();
    for (int k = 0; k < NEVAL; k++) resp_q.push_back(seq[k]);
    rise_q.delete();
    high_cnt = 0;
  endtask

  // Majority: a bit is 1 when more samples were 1 than 0.
  task automatic ref_vote(output logic [RW-1:0] d, output logic [RW-1:0] u);
    for (int i = 0; i < RW; i++) begin
      int ones;
      ones = 0;
      for (int k = 0; k < NEVAL; k++) ones += int'(seq[k][i]);
      d[i] = (2 * ones > NEVAL);
      u[i] = (ones > 0) && (ones < NEVAL);
    end
  endtask

  task automatic start_cmd(input logic [CW-1:0] ch, output int acc);
    logic rdy;
    acc = -1;
    cmd_challenge = ch;
    cmd_valid = 1'b1;
    for (int i = 0; i < 100 && acc < 0; i++) begin
      rdy = cmd_ready;
      step();
      if (rdy === 1'b1) acc = cyc;
    end
    chk("accept", 32'(acc >= 0), 32'd1);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_result(input int acc, input logic [CW-1:0] ch, input string tag);
    int vcyc;
    logic [RW-1:0] ed, eu;
    vcyc = -1;
    for (int i = 0; i < NEVAL * P + 20 && vcyc < 0; i++) begin
      step();
      if (out_valid === 1'b1) vcyc = cyc;
    end
    chk({tag, ".valid_at"}, 32'(vcyc), 32'(acc + NEVAL * P));
    chk({tag, ".npulse"}, 32'(rise_q.size()), 32'(NEVAL));
    for (int k = 0; k < rise_q.size(); k++)
      chk({tag, ".pulse_at"}, 32'(rise_q[k]), 32'(acc + 1 + k * P));
    chk({tag, ".pulse_hi"}, 32'(high_cnt), 32'(NEVAL * PULSE_W));
    ref_vote(ed, eu);
    chk({tag, ".data"}, 32'(out_data), 32'(ed));
    chk({tag, ".unstable"}, 32'(out_unstable), 32'(eu));
    chk({tag, ".challenge"}, 32'(puf_challenge), 32'(ch));
    chk({tag, ".busy"}, 32'(busy), 32'd1);
  endtask

  task automatic handshake(input string tag);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk({tag, ".hs_valid"}, 32'(out_valid), 32'd0);
    chk({tag, ".hs_busy"}, 32'(busy), 32'd0);
    chk({tag, ".hs_ready"}, 32'(cmd_ready), 32'd1);
  endtask

  initial begin
    int acc, acc2, hs, nv;
    logic [CW-1:0] ch;
    logic [RW-1:0] held;

    rst = 1'b1; cmd_valid = 1'b0; out_ready = 1'b0;
    cmd_challenge = '0; puf_response = '0;

    // Reset values
    step(); step(); step();
    chk("rst.cmd_ready", 32'(cmd_ready), 32'd0);
    chk("rst.pulse", 32'(puf_pulse), 32'd0);
    chk("rst.challenge", 32'(puf_challenge), 32'd0);
    chk("rst.out_valid", 32'(out_valid), 32'd0);
    chk("rst.out_data", 32'(out_data), 32'd0);
    chk("rst.out_unstable", 32'(out_unstable), 32'd0);
    chk("rst.busy", 32'(busy), 32'd0);
    rst = 1'b0;
    #1;
    chk("rst.ready_after", 32'(cmd_ready), 32'd1);

    // Stable array
    for (int k = 0; k < NEVAL; k++) seq[k] = 16'hA5C3;
    ch = 16'($urandom);
    arm();
    start_cmd(ch, acc);
    wait_result(acc, ch, "stable");
    chk("stable.const", 32'(out_data), 32'h0000A5C3);

    // Back-pressure: result frozen, no activity, while out_ready is low
    held = out_data;
    nv = rise_q.size();
    for (int i = 0; i < 10; i++) begin
      step();
      chk("bp.valid", 32'(out_valid), 32'd1);
      chk("bp.data", 32'(out_data), 32'(held));
      chk("bp.pulse", 32'(puf_pulse), 32'd0);
      chk("bp.busy", 32'(busy), 32'd1);
      chk("bp.cmd_ready", 32'(cmd_ready), 32'd0);
    end
    chk("bp.no_pulses", 32'(rise_q.size()), 32'(nv));
    handshake("bp");

    // Noisy bit0, majority 1
    seq[0] = 16'h0001; seq[1] = 16'h0000; seq[2] = 16'h0001;
    seq[3] = 16'h0000; seq[4] = 16'h0001;
    arm();
    start_cmd(16'h0F0F, acc);
    wait_result(acc, 16'h0F0F, "noisy1");
    chk("noisy1.const_d", 32'(out_data), 32'h1);
    chk("noisy1.const_u", 32'(out_unstable), 32'h1);
    handshake("noisy1");

    // Noisy bit0, majority 0
    seq[0] = 16'h0000; seq[1] = 16'h0001; seq[2] = 16'h0000;
    seq[3] = 16'h0001; seq[4] = 16'h0000;
    arm();
    start_cmd(16'hF0F0, acc);
    wait_result(acc, 16'hF0F0, "noisy0");
    chk("noisy0.const_d", 32'(out_data), 32'h0);
    chk("noisy0.const_u", 32'(out_unstable), 32'h1);
    handshake("noisy0");

    // Random responses with random result latency
    for (int r = 0; r < 6; r++) begin
      int dly;
      for (int k = 0; k < NEVAL; k++) seq[k] = RW'($urandom);
      ch = 16'($urandom);
      arm();
      start_cmd(ch, acc);
      wait_result(acc, ch, "rand");
      dly = int'($urandom_range(0, 3));
      for (int i = 0; i < dly; i++) begin
        step();
        chk("rand.hold", 32'(out_valid), 32'd1);
      end
      handshake("rand");
    end

    // Command while busy is ignored until IDLE
    for (int k = 0; k < NEVAL; k++) seq[k] = RW'($urandom);
    arm();
    start_cmd(16'h1234, acc);
    step(); step(); step();
    cmd_challenge = 16'hFFFF;
    cmd_valid = 1'b1;
    wait_result(acc, 16'h1234, "busycmd");
    for (int k = 0; k < NEVAL; k++) seq[k] = RW'($urandom);
    arm();
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("busycmd.hs_ready", 32'(cmd_ready), 32'd1);
    chk("busycmd.hold_ch", 32'(puf_challenge), 32'h1234);
    step();
    acc = cyc;
    cmd_valid = 1'b0;
    chk("busycmd.second_ch", 32'(puf_challenge), 32'hFFFF);
    chk("busycmd.second_busy", 32'(busy), 32'd1);
    wait_result(acc, 16'hFFFF, "second");
    handshake("second");

    // Back-to-back with out_ready tied high
    out_ready = 1'b1;
    for (int k = 0; k < NEVAL; k++) seq[k] = RW'($urandom);
    arm();
    start_cmd(16'h0001, acc);
    cmd_challenge = 16'h8000;
    cmd_valid = 1'b1;
    wait_result(acc, 16'h0001, "b2b1");
    hs = cyc + 1;
    for (int k = 0; k < NEVAL; k++) seq[k] = RW'($urandom);
    arm();
    start_cmd(16'h8000, acc2);
    chk("b2b.accept_at", 32'(acc2), 32'(hs + 1));
    wait_result(acc2, 16'h8000, "b2b2");
    step();
    chk("b2b.done_idle", 32'(busy), 32'd0);
    out_ready = 1'b0;

    // Reset during PULSE aborts the command
    for (int k = 0; k < NEVAL; k++) seq[k] = RW'($urandom);
    arm();
    start_cmd(16'hBEEF, acc);
    step();
    chk("rmid.in_pulse", 32'(puf_pulse), 32'd1);
    rst = 1'b1;
    step();
    chk("rmid.pulse_low", 32'(puf_pulse), 32'd0);
    chk("rmid.ready_low", 32'(cmd_ready), 32'd0);
    step(); step();
    chk("rmid.ready_low2", 32'(cmd_ready), 32'd0);
    rst = 1'b0;
    #1;
    chk("rmid.ready_after", 32'(cmd_ready), 32'd1);
    chk("rmid.busy_after", 32'(busy), 32'd0);
    rise_q.delete();
    nv = 0;
    for (int i = 0; i < 60; i++) begin
      step();
      if (out_valid !== 1'b0) nv++;
    end
    chk("rmid.no_valid", 32'(nv), 32'd0);
    chk("rmid.no_pulses", 32'(rise_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
